// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit with a 2-entry prefetch buffer and redirect flush
// Streams 16-bit words from memory into a small FIFO and hands them to the instruction register on request.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] memData,
  output logic        IRWrite,
  output logic [15:0] pc_out,
  output logic        busy
);

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_DROP} mstate_t;

  mstate_t     mstate, mstate_next;
  logic [15:0] fpc, fpc_next;
  logic        mem_rd_next;
  logic [15:0] mem_addr_next;
  logic        push;
  logic        deliver;
  logic        pending;
  logic [1:0]  count;
  logic [15:0] fifo_addr [2];
  logic [15:0] fifo_data [2];

  assign push    = (mstate == M_REQ) && mem_ack && !pc_load;
  assign deliver = (pending || fetch_req) && (count != 2'd0) && !pc_load;
  assign busy    = pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstate   <= M_IDLE;
      fpc      <= RESET_PC;
      mem_rd   <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      mstate   <= mstate_next;
      fpc      <= fpc_next;
      mem_rd   <= mem_rd_next;
      mem_addr <= mem_addr_next;
    end
  end

  always_comb begin
    mstate_next   = mstate;
    mem_rd_next   = mem_rd;
    mem_addr_next = mem_addr;
    fpc_next      = fpc;
    if (pc_load)
      fpc_next = pc_in;
    else if (push)
      fpc_next = fpc + PC_STEP;
    case (mstate)
      M_IDLE: begin
        if ((count != 2'd2) && !pc_load) begin
          mstate_next   = M_REQ;
          mem_rd_next   = 1'b1;
          mem_addr_next = fpc;
        end else begin
          mem_rd_next   = 1'b0;
          mem_addr_next = fpc_next;
        end
      end
      M_REQ: begin
        if (mem_ack) begin
          mstate_next   = M_IDLE;
          mem_rd_next   = 1'b0;
          mem_addr_next = fpc_next;
        end else if (pc_load) begin
          // Request cannot be withdrawn; wait out its ack and discard the data.
          mstate_next = M_DROP;
        end
      end
      M_DROP: begin
        if (mem_ack) begin
          mstate_next   = M_IDLE;
          mem_rd_next   = 1'b0;
          mem_addr_next = fpc_next;
        end
      end
      default: begin
        mstate_next = M_IDLE;
        mem_rd_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= 2'd0;
      pending      <= 1'b0;
      IRWrite      <= 1'b0;
      memData      <= 16'h0000;
      pc_out       <= 16'h0000;
      fifo_addr[0] <= 16'h0000;
      fifo_addr[1] <= 16'h0000;
      fifo_data[0] <= 16'h0000;
      fifo_data[1] <= 16'h0000;
    end else begin
      IRWrite <= deliver;
      if (deliver) begin
        pending <= 1'b0;
        memData <= fifo_data[0];
        pc_out  <= fifo_addr[0];
      end else if (fetch_req) begin
        pending <= 1'b1;
      end
      if (pc_load) begin
        count <= 2'd0;
      end else begin
        case ({push, deliver})
          2'b10: begin
            fifo_addr[count[0]] <= mem_addr;
            fifo_data[count[0]] <= mem_rdata;
            count               <= count + 2'd1;
          end
          2'b01: begin
            fifo_addr[0] <= fifo_addr[1];
            fifo_data[0] <= fifo_data[1];
            count        <= count - 2'd1;
          end
          2'b11: begin
            // Simultaneous push and pop: occupancy unchanged, new word goes behind any survivor.
            if (count == 2'd1) begin
              fifo_addr[0] <= mem_addr;
              fifo_data[0] <= mem_rdata;
            end else begin
              fifo_addr[0] <= fifo_addr[1];
              fifo_data[0] <= fifo_data[1];
              fifo_addr[1] <= mem_addr;
              fifo_data[1] <= mem_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] memData;
  logic        IRWrite;
  logic [15:0] pc_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  bit mem_en = 1'b0;

  instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .memData(memData), .IRWrite(IRWrite), .pc_out(pc_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1234;
      16'h0002: mem_word = 16'hABCD;
      default:  mem_word = 16'hEEEE;
    endcase
  endfunction

  // Auto-responder: acks one cycle after mem_rd rises while enabled.
  always begin
    @(posedge clk); #1;
    if (mem_en) begin
      mem_ack = 1'b0;
      if (mem_rd) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL rst_mem_rd got=%h exp=0", mem_rd); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL rst_irwrite got=%h exp=0", IRWrite); end
    vectors++; if (memData !== 16'h0000) begin miscompares++; $display("FAIL rst_memdata got=%h exp=0000", memData); end
    vectors++; if (pc_out !== 16'h0000) begin miscompares++; $display("FAIL rst_pc_out got=%h exp=0000", pc_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%h exp=0", busy); end
  endtask

  task automatic test_fill;
    logic [15:0] seen [4];
    int n = 0;
    logic prev = 1'b0;
    mem_en = 1'b1;
    reset  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_rd && !prev) begin
        if (n < 4) seen[n] = mem_addr;
        n++;
      end
      prev = mem_rd;
    end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL fill_issue_count got=%0d exp=2", n); end
    vectors++; if (seen[0] !== 16'h0000) begin miscompares++; $display("FAIL fill_addr0 got=%h exp=0000", seen[0]); end
    vectors++; if (seen[1] !== 16'h0002) begin miscompares++; $display("FAIL fill_addr1 got=%h exp=0002", seen[1]); end
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL fill_stopped got=%h exp=0", mem_rd); end
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL fill_irwrite got=%h exp=0", IRWrite); end
  endtask

  task automatic test_deliver_full;
    mem_en  = 1'b0;
    mem_ack = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    vectors++; if (IRWrite !== 1'b1) begin miscompares++; $display("FAIL full_irwrite got=%h exp=1", IRWrite); end
    vectors++; if (memData !== 16'h1234) begin miscompares++; $display("FAIL full_memdata got=%h exp=1234", memData); end
    vectors++; if (pc_out !== 16'h0000) begin miscompares++; $display("FAIL full_pc_out got=%h exp=0000", pc_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy got=%h exp=0", busy); end
    tick();
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL full_irwrite_pulse got=%h exp=0", IRWrite); end
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL full_refill_rd got=%h exp=1", mem_rd); end
    vectors++; if (mem_addr !== 16'h0004) begin miscompares++; $display("FAIL full_refill_addr got=%h exp=0004", mem_addr); end
  endtask

  task automatic test_redirect_inflight;
    fetch_req = 1'b1;
    pc_load   = 1'b1;
    pc_in     = 16'h0100;
    tick();
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL redir_no_irwrite got=%h exp=0", IRWrite); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL redir_busy got=%h exp=1", busy); end
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL redir_rd_held got=%h exp=1", mem_rd); end
    vectors++; if (mem_addr !== 16'h0004) begin miscompares++; $display("FAIL redir_addr_held got=%h exp=0004", mem_addr); end
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL redir_drop_done got=%h exp=0", mem_rd); end
    vectors++; if (memData !== 16'h1234) begin miscompares++; $display("FAIL redir_no_dead got=%h exp=1234", memData); end
    tick();
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL redir_flushed got=%h exp=0", IRWrite); end
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL redir_new_rd got=%h exp=1", mem_rd); end
    vectors++; if (mem_addr !== 16'h0100) begin miscompares++; $display("FAIL redir_new_addr got=%h exp=0100", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h0B00;
    tick();
    mem_ack = 1'b0;
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL redir_no_bypass got=%h exp=0", IRWrite); end
    tick();
    vectors++; if (IRWrite !== 1'b1) begin miscompares++; $display("FAIL redir_deliver got=%h exp=1", IRWrite); end
    vectors++; if (memData !== 16'h0B00) begin miscompares++; $display("FAIL redir_memdata got=%h exp=0b00", memData); end
    vectors++; if (pc_out !== 16'h0100) begin miscompares++; $display("FAIL redir_pc_out got=%h exp=0100", pc_out); end
    vectors++; if (mem_addr !== 16'h0102) begin miscompares++; $display("FAIL redir_next_addr got=%h exp=0102", mem_addr); end
  endtask

  task automatic test_empty_delayed;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL empty_busy_set got=%h exp=1", busy); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (busy !== 1'b1 || IRWrite !== 1'b0) begin miscompares++; $display("FAIL empty_wait%0d busy=%h irwrite=%h exp busy=1 irwrite=0", i, busy, IRWrite); end
    end
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    vectors++; if (IRWrite !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL empty_ack_edge irwrite=%h busy=%h exp irwrite=0 busy=1", IRWrite, busy); end
    tick();
    vectors++; if (IRWrite !== 1'b1) begin miscompares++; $display("FAIL empty_irwrite got=%h exp=1", IRWrite); end
    vectors++; if (memData !== 16'h5A5A) begin miscompares++; $display("FAIL empty_memdata got=%h exp=5a5a", memData); end
    vectors++; if (pc_out !== 16'h0102) begin miscompares++; $display("FAIL empty_pc_out got=%h exp=0102", pc_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy_clr got=%h exp=0", busy); end
    tick();
    vectors++; if (IRWrite !== 1'b0) begin miscompares++; $display("FAIL empty_pulse got=%h exp=0", IRWrite); end
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0104) begin miscompares++; $display("FAIL empty_next rd=%h addr=%h exp rd=1 addr=0104", mem_rd, mem_addr); end
  endtask

  task automatic test_reset_midwait;
    reset = 1'b1;
    #1;
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rd got=%h exp=0", mem_rd); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_addr got=%h exp=0000", mem_addr); end
    vectors++; if (memData !== 16'h0000 || pc_out !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_data memData=%h pc_out=%h exp 0000/0000", memData, pc_out); end
    vectors++; if (IRWrite !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_strobes irwrite=%h busy=%h exp 0/0", IRWrite, busy); end
    tick();
    reset = 1'b0;
    tick();
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin miscompares++; $display("FAIL mid_restart rd=%h addr=%h exp rd=1 addr=0000", mem_rd, mem_addr); end
  endtask

  task automatic test_wrap;
    pc_load = 1'b1;
    pc_in   = 16'hFFFE;
    tick();
    pc_load = 1'b0;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin miscompares++; $display("FAIL wrap_drop rd=%h addr=%h exp rd=1 addr=0000", mem_rd, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    tick();
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_top rd=%h addr=%h exp rd=1 addr=fffe", mem_rd, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr rd=%h addr=%h exp rd=1 addr=0000", mem_rd, mem_addr); end
    vectors++; if (IRWrite !== 1'b1 || memData !== 16'h7777 || pc_out !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_deliver irwrite=%h memData=%h pc_out=%h exp 1/7777/fffe", IRWrite, memData, pc_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_deliver_full();
    test_redirect_inflight();
    test_empty_delayed();
    test_reset_midwait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
